// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write sequencer for a shared WIDTH-bit register.
// Define ARB_WCOUNT_EN to add the saturating completed-write counter port wcount_o.
module reg_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [3:0]         req_i,
  input  logic [4*WIDTH-1:0] din_i,
  output logic [3:0]         grant_o,
  output logic [WIDTH-1:0]   q_o,
  output logic               busy_o,
  output logic               done_o
`ifdef ARB_WCOUNT_EN
  ,
  output logic [7:0]         wcount_o
`endif
);
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, g_q, g_d, sel;
  logic [3:0] grant_q, grant_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic wr;
  // Descending scan so the requester closest to ptr_q wins.
  always_comb begin
    sel = ptr_q;
    for (int k = 3; k >= 0; k--) if (req_i[ptr_q + 2'(k)]) sel = ptr_q + 2'(k);
  end
  assign wr = (state_q == GRANT) && req_i[g_q];
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    q_d     = q_q;
    grant_d = '0;
    case (state_q)
      IDLE: if (|req_i) begin
        state_d = GRANT;
        g_d     = sel;
        grant_d = 4'b0001 << sel;
      end
      GRANT: begin
        state_d = wr ? DONE : IDLE;
        q_d     = wr ? din_i[g_q*WIDTH +: WIDTH] : q_q;
        ptr_d   = wr ? g_q + 2'd1 : ptr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      grant_q <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      q_q     <= q_d;
    end
  end
  assign grant_o = grant_q;
  assign q_o     = q_q;
  assign busy_o  = state_q != IDLE;
  assign done_o  = state_q == DONE;
`ifdef ARB_WCOUNT_EN
  logic [7:0] wcount_q, wcount_d;
  assign wcount_d = (wr && wcount_q != 8'hFF) ? wcount_q + 8'd1 : wcount_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) wcount_q <= '0;
    else wcount_q <= wcount_d;
  end
  assign wcount_o = wcount_q;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and randomized checks against a transaction-level model.
module tb_reg_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [31:0] din = '0;
  logic [3:0] grant;
  logic [7:0] q;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  int m_phase = 0, m_g = 0, m_ptr = 0, m_cnt = 0;
  logic [7:0] m_q = '0;
  bit m_valid = 1'b0;
`ifdef ARB_WCOUNT_EN
  logic [7:0] wcount;
`endif

  reg_write_arbiter #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din),
    .grant_o(grant), .q_o(q), .busy_o(busy), .done_o(done)
`ifdef ARB_WCOUNT_EN
    , .wcount_o(wcount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  // Model phases: 0 idle, 1 granted to m_g, 2 write just completed.
  always @(posedge clk) begin
    m_valid = 1'b1;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_q = '0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (req != 0) begin m_g = pick(req, m_ptr); m_phase = 1; end
    end else if (m_phase == 1) begin
      if (req[m_g]) begin
        m_q = din[m_g*8 +: 8];
        m_ptr = (m_g + 1) % 4;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_phase = 2;
      end else m_phase = 0;
    end else m_phase = 0;
  end

  always @(negedge clk) if (m_valid) begin
    chk("grant", 32'(grant), (m_phase == 1) ? 32'(1 << m_g) : 32'd0);
    chk("q", 32'(q), 32'(m_q));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 2));
`ifdef ARB_WCOUNT_EN
    chk("wcount", 32'(wcount), 32'(m_cnt));
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    cyc(2);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0; req = 4'b0000;
    cyc(1);
    req = 4'b0100; din = 32'h00A5_0000;
    cyc(1);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_busy", 32'(busy), 32'h1);
    cyc(1);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_done", 32'(done), 32'h1);
    chk("single_grant_off", 32'(grant), 32'h0);
    req = 4'b0000;
    cyc(1);
    chk("single_idle", 32'(busy), 32'h0);
    req = 4'b1111;
    cyc(1);
    chk("ptr3_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; req = 4'b1111; din = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("rot_grant", 32'(grant), 32'(1 << (i % 4)));
      cyc(1);
      chk("rot_q", 32'(q), 32'h10 + 32'(i % 4));
      chk("rot_done", 32'(done), 32'h1);
      if (i == 4) req = 4'b0000;
      cyc(1);
      chk("rot_idle", 32'(busy), 32'h0);
    end
    req = 4'b0010;
    cyc(1);
    chk("abort_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    cyc(1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_q", 32'(q), 32'h10);
    req = 4'b0011;
    cyc(1);
    chk("abort_ptr_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    cyc(2);
    req = 4'b0001; din = 32'h0000_00FF;
    cyc(1);
    chk("midrst_grant", 32'(grant), 32'h1);
    rst = 1'b1;
    cyc(1);
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    rst = 1'b0; req = 4'b0000;
    cyc(1);
    chk("midrst_nodone", 32'(done), 32'h0);
`ifdef ARB_WCOUNT_EN
    req = 4'b0001;
    cyc(900);
    req = 4'b0000;
    cyc(3);
    chk("wcount_sat", 32'(wcount), 32'd255);
    req = 4'b0001;
    cyc(1);
    req = 4'b0000;
    cyc(2);
    chk("wcount_abort", 32'(wcount), 32'd255);
`endif
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(3) == 0) req = 4'($urandom);
      if ($urandom_range(1) == 0) din = $urandom;
      cyc(1);
    end
    rst = 1'b0; req = 4'b0000;
    cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
